fp_addsub_arbiter: RTL and testbench

Round-robin arbiter that shares one combinational `fp_addsub` core among `NUM_REQ` independent requesters. Each requester presents a 32-bit IEEE-754 operand pair and an add/sub select on a valid/ready channel, and receives its result on a private valid/ready response channel. The block sits between the byte-serial front ends (ALU controllers) and the single FP adder, sustaining one issued operation per cycle aggregate.

---
 rtl/fp_arb_pkg.sv | 30 +++
 rtl/fp_addsub.sv | 86 ++++++++
 rtl/fp_addsub_arbiter.sv | 108 ++++++++++
 tb/tb_fp_addsub_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_arb_pkg.sv
// Shared types and helpers for the round-robin FP add/sub arbiter.
package fp_arb_pkg;

  localparam int FP_W        = 32;
  localparam int NUM_REQ_DEF = 4;
  localparam int MAX_REQ     = 8;
  localparam int TAG_W       = 3;

  typedef struct packed {
    logic [FP_W-1:0]  a;
    logic [FP_W-1:0]  b;
    logic             sub;
    logic [TAG_W-1:0] tag;
  } issue_rec_t;

  // Returns {found, index}; the search starts one past 'last' and wraps modulo n.
  function automatic logic [TAG_W:0] rr_next(input logic [MAX_REQ-1:0] elig,
                                             input logic [TAG_W-1:0]   last,
                                             input int unsigned        n);
    logic [TAG_W:0] pick;
    int unsigned    idx;
    pick = '0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      idx = (32'(last) + k) % n;
      if (k <= n && !pick[TAG_W] && elig[idx]) pick = {1'b1, idx[TAG_W-1:0]};
    end
    return pick;
  endfunction

endpackage

// File: rtl/fp_addsub.sv
// Combinational IEEE-754 single-precision adder/subtractor, round-to-nearest-even.
module fp_addsub
  import fp_arb_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  input  logic            sub,
  output logic [FP_W-1:0] result
);

  logic        sb_eff, swap, sl, ss, rnd;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic [7:0]  el, es, d;
  logic [23:0] ml, ms;
  logic [26:0] ms_ext, ms_al, lost_mask, n;
  logic [27:0] s;
  logic [9:0]  e;
  logic [4:0]  lz, shamt;
  logic [24:0] mant;
  logic [22:0] frac;

  always_comb begin
    sb_eff = b[31] ^ sub;
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != '0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != '0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == '0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == '0);

    // Order by magnitude so the aligned operand is always the smaller one.
    swap = b[30:0] > a[30:0];
    {sl, el, ml[22:0]} = swap ? {sb_eff, b[30:0]} : {a[31], a[30:0]};
    {ss, es, ms[22:0]} = swap ? {a[31], a[30:0]} : {sb_eff, b[30:0]};
    ml[23] = (el != 8'd0);
    ms[23] = (es != 8'd0);
    if (el == 8'd0) el = 8'd1;
    if (es == 8'd0) es = 8'd1;

    d         = el - es;
    ms_ext    = {ms, 3'b000};
    lost_mask = '0;
    if (d >= 8'd27) begin
      ms_al = {26'd0, |ms};
    end else begin
      lost_mask = ~({27{1'b1}} << d);
      ms_al     = (ms_ext >> d) | {26'd0, |(ms_ext & lost_mask)};
    end

    if (sl == ss) s = {1'b0, ml, 3'b000} + {1'b0, ms_al};
    else          s = {1'b0, ml, 3'b000} - {1'b0, ms_al};

    lz = '0;
    for (int unsigned i = 0; i < 27; i++) begin
      if (s[i]) lz = 5'(26 - i);
    end

    e     = {2'b00, el};
    shamt = '0;
    if (s[27]) begin
      n = {s[27:2], s[1] | s[0]};
      e = e + 10'd1;
    end else begin
      // Left shift stops at the minimum exponent so tiny results come out subnormal.
      shamt = ((e - 10'd1) < {5'd0, lz}) ? 5'(e - 10'd1) : lz;
      n     = s[26:0] << shamt;
      e     = e - {5'd0, shamt};
    end

    rnd  = n[2] & (n[1] | n[0] | n[3]);
    mant = {1'b0, n[26:3]} + {24'd0, rnd};
    if (mant[24]) begin
      e    = e + 10'd1;
      frac = mant[23:1];
    end else begin
      if (!mant[23]) e = '0;
      frac = mant[22:0];
    end

    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != sb_eff))) result = 32'h7FC0_0000;
    else if (a_inf)                                              result = {a[31], 8'hFF, 23'd0};
    else if (b_inf)                                              result = {sb_eff, 8'hFF, 23'd0};
    else if (s == '0)                                            result = {a[31] & sb_eff, 31'd0};
    else if (e >= 10'd255)                                       result = {sl, 8'hFF, 23'd0};
    else                                                         result = {sl, e[7:0], frac};
  end

endmodule

// File: rtl/fp_addsub_arbiter.sv
// Round-robin arbiter sharing one fp_addsub core among NUM_REQ requesters,
// with a one-deep result slot per requester.
module fp_addsub_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [FP_W*NUM_REQ-1:0] req_a,
  input  logic [FP_W*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]      req_sub,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [FP_W*NUM_REQ-1:0] rsp_result,
  output logic                    busy,
  output logic [CNT_W-1:0]        op_count
);

  issue_rec_t                issue_q, issue_d;
  logic                      issue_valid_q, issue_valid_d;
  logic [TAG_W-1:0]          last_grant_q, last_grant_d;
  logic [NUM_REQ-1:0]        slot_full_q, slot_full_d;
  logic [FP_W*NUM_REQ-1:0]   slot_q, slot_d;
  logic [CNT_W-1:0]          op_count_q, op_count_d;

  logic [NUM_REQ-1:0]        inflight, eligible;
  logic [MAX_REQ-1:0]        elig_ext;
  logic [TAG_W:0]            pick;
  logic [FP_W-1:0]           fp_res;

  fp_addsub u_fp_addsub (
    .a      (issue_q.a),
    .b      (issue_q.b),
    .sub    (issue_q.sub),
    .result (fp_res)
  );

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      inflight[i] = issue_valid_q && (issue_q.tag == TAG_W'(i));
    end
    eligible                = req_valid & ~inflight & ~slot_full_q;
    elig_ext                = '0;
    elig_ext[NUM_REQ-1:0]   = eligible;
    pick                    = rr_next(elig_ext, last_grant_q, NUM_REQ);
    req_ready               = '0;
    // Held in reset, no transfer may be acknowledged.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = pick[TAG_W] && (pick[TAG_W-1:0] == TAG_W'(i)) && !rst;
    end
  end

  always_comb begin
    issue_d       = issue_q;
    issue_valid_d = |req_ready;
    last_grant_d  = last_grant_q;
    slot_full_d   = slot_full_q;
    slot_d        = slot_q;
    op_count_d    = op_count_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        issue_d.a    = req_a[i*FP_W +: FP_W];
        issue_d.b    = req_b[i*FP_W +: FP_W];
        issue_d.sub  = req_sub[i];
        issue_d.tag  = TAG_W'(i);
        last_grant_d = TAG_W'(i);
      end
      if (slot_full_q[i] && rsp_ready[i]) begin
        slot_full_d[i] = 1'b0;
        op_count_d     = op_count_d + CNT_W'(1);
      end
      // Issue never targets a full slot, so drain and fill never collide on one index.
      if (issue_valid_q && (issue_q.tag == TAG_W'(i))) begin
        slot_full_d[i]            = 1'b1;
        slot_d[i*FP_W +: FP_W]    = fp_res;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_q       <= '0;
      issue_valid_q <= 1'b0;
      last_grant_q  <= TAG_W'(NUM_REQ - 1);
      slot_full_q   <= '0;
      slot_q        <= '0;
      op_count_q    <= '0;
    end else begin
      issue_q       <= issue_d;
      issue_valid_q <= issue_valid_d;
      last_grant_q  <= last_grant_d;
      slot_full_q   <= slot_full_d;
      slot_q        <= slot_d;
      op_count_q    <= op_count_d;
    end
  end

  assign rsp_valid  = slot_full_q;
  assign rsp_result = slot_q;
  assign busy       = issue_valid_q | (|slot_full_q);
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Self-checking bench for fp_addsub_arbiter: vector table plus scoreboard per requester.
module tb_fp_addsub_arbiter;
  import fp_arb_pkg::*;

  localparam int N  = 4;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid, req_ready, req_sub, rsp_valid, rsp_ready;
  logic [32*N-1:0]   req_a, req_b, rsp_result;
  logic              busy;
  logic [CW-1:0]     op_count;

  fp_addsub_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned req;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] exp;
  } vec_t;

  vec_t          pend_q [N][$];
  logic [31:0]   sb_q   [N][$];
  int unsigned   grant_q [$];
  bit            hs [N];
  int            n_vec = 0;
  int            n_err = 0;
  int unsigned   tot_ops = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] int2fp(input int v);
    logic [31:0] mag;
    int          msb;
    logic        s;
    if (v == 0) return 32'h0;
    s   = (v < 0);
    mag = s ? -v : v;
    msb = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) msb = i;
    return {s, 8'(127 + msb), 23'(mag << (23 - msb))};
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (pend_q[i].size() != 0 || sb_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push(input vec_t v);
    pend_q[v.req].push_back(v);
    tot_ops++;
  endtask

  task automatic wait_idle(input string name, input int unsigned max_cyc);
    int unsigned c = 0;
    while (c < max_cyc && !(all_empty() && !busy)) begin
      @(negedge clk);
      c++;
    end
    if (c >= max_cyc) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: not idle after %0d cycles, required idle", name, max_cyc);
    end
  endtask

  task automatic wait_hs(input string name, input int unsigned r, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (req_valid[r] && req_ready[r]) ok = 1'b1;
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: no grant to requester %0d within 20 cycles, required a grant", name, r);
    end
  endtask

  // Latency check: handshake in cycle t, nothing in t+1, result slot in t+2.
  task automatic single_op(input string name, input vec_t v, input logic [N-1:0] exp_valid);
    bit ok;
    push(v);
    wait_hs(name, v.req, ok);
    if (ok) begin
      @(negedge clk);
      chk({name, "_rsp_valid_t1"}, rsp_valid, '0);
      @(negedge clk);
      chk({name, "_rsp_valid_t2"}, rsp_valid, exp_valid);
      @(negedge clk);
      chk({name, "_op_count"}, op_count, CW'(tot_ops));
      chk({name, "_busy"}, busy, 1'b0);
    end
  endtask

  // Driver: present the head of each pending queue; retire it after a handshake.
  initial begin : driver
    vec_t vtmp;
    req_valid = '0; req_a = '0; req_b = '0; req_sub = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          hs[i] = 1'b0;
          if (pend_q[i].size() > 0) vtmp = pend_q[i].pop_front();
        end
        if (pend_q[i].size() > 0) begin
          req_valid[i]        = 1'b1;
          req_a[i*32 +: 32]   = pend_q[i][0].a;
          req_b[i*32 +: 32]   = pend_q[i][0].b;
          req_sub[i]          = pend_q[i][0].sub;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: scoreboard push on request handshake, compare while a result is held.
  initial begin : monitor
    logic [31:0] dtmp;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < N; i++) begin
          if (req_valid[i] && req_ready[i] && pend_q[i].size() > 0) begin
            sb_q[i].push_back(pend_q[i][0].exp);
            hs[i] = 1'b1;
            grant_q.push_back(i);
          end
          if (rsp_valid[i]) begin
            if (sb_q[i].size() == 0) begin
              n_vec++;
              n_err++;
              $display("FAIL rsp_unexpected[%0d]: rsp_valid 1 with nothing outstanding, required 0", i);
            end else begin
              chk($sformatf("rsp_result[%0d]", i), rsp_result[i*32 +: 32], sb_q[i][0]);
              if (rsp_ready[i]) dtmp = sb_q[i].pop_front();
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  vec_t table_v [12];

  initial begin : main
    bit   ok;
    vec_t v;
    int   x, y;

    table_v[0]  = '{0, 32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000}; // 1.5+1.5
    table_v[1]  = '{1, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000}; // 1-1 = +0
    table_v[2]  = '{2, 32'h40000000, 32'hBF000000, 1'b0, 32'h3FC00000}; // 2+(-0.5)
    table_v[3]  = '{3, 32'hBF800000, 32'h3F800000, 1'b1, 32'hC0000000}; // -1-1
    table_v[4]  = '{0, 32'h00000000, 32'h3F800000, 1'b0, 32'h3F800000}; // 0+1
    table_v[5]  = '{1, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000}; // tie to even
    table_v[6]  = '{2, 32'h3F800000, 32'h34000000, 1'b0, 32'h3F800001}; // 1+ulp
    table_v[7]  = '{3, 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000}; // inf+1
    table_v[8]  = '{0, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000}; // inf-inf
    table_v[9]  = '{1, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000}; // overflow
    table_v[10] = '{2, 32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF}; // into subnormal
    table_v[11] = '{3, 32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000}; // deep cancel

    rst = 1'b1;
    rsp_ready = '1;
    repeat (2) @(negedge clk);
    chk("reset_req_ready",  req_ready,  '0);
    chk("reset_rsp_valid",  rsp_valid,  '0);
    chk("reset_rsp_result", rsp_result, '0);
    chk("reset_busy",       busy,       1'b0);
    chk("reset_op_count",   op_count,   '0);
    @(posedge clk); #2; rst = 1'b0;

    single_op("add_r0", '{0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000}, 4'b0001);
    single_op("sub_r2", '{2, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000}, 4'b0100);

    for (int i = 0; i < 12; i++) push(table_v[i]);
    wait_idle("table_idle", 300);
    chk("table_op_count", op_count, CW'(tot_ops));

    // Backpressure on requester 1 while requester 0 keeps streaming.
    @(posedge clk); #2; rsp_ready[1] = 1'b0;
    push('{1, int2fp(5), int2fp(3), 1'b0, int2fp(8)});
    push('{1, int2fp(9), int2fp(4), 1'b1, int2fp(5)});
    for (int k = 0; k < 4; k++) push('{0, int2fp(k + 10), int2fp(k), 1'b0, int2fp(2 * k + 10)});
    ok = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rsp_valid[1]) ok = 1'b1;
      if (ok) chk("bp_req_ready1", req_ready[1], 1'b0);
    end
    chk("bp_rsp_valid1_held", rsp_valid[1], 1'b1);
    chk("bp_req0_completed", pend_q[0].size() + sb_q[0].size(), 0);
    @(posedge clk); #2; rsp_ready[1] = 1'b1;
    wait_idle("bp_release_idle", 100);
    chk("bp_op_count_wrapped", op_count, CW'(tot_ops));

    // Reset the cycle after a grant: everything in flight is dropped.
    push('{1, int2fp(1), int2fp(1), 1'b0, int2fp(2)});
    wait_hs("rst_grant", 1, ok);
    @(posedge clk); #2;
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      pend_q[i].delete();
      sb_q[i].delete();
      hs[i] = 1'b0;
    end
    tot_ops = 0;
    #1;
    chk("midrst_req_ready",  req_ready,  '0);
    chk("midrst_rsp_valid",  rsp_valid,  '0);
    chk("midrst_rsp_result", rsp_result, '0);
    chk("midrst_busy",       busy,       1'b0);
    chk("midrst_op_count",   op_count,   '0);
    push('{3, int2fp(7), int2fp(2), 1'b0, int2fp(9)});
    push('{0, int2fp(7), int2fp(2), 1'b1, int2fp(5)});
    repeat (2) @(posedge clk);
    #2;
    grant_q.delete();
    rst = 1'b0;
    wait_idle("rst_release_idle", 50);
    chk("rst_grant_count", grant_q.size(), 2);
    chk("rst_first_grant", grant_q.size() > 0 ? grant_q[0] : 99, 0);
    chk("rst_second_grant", grant_q.size() > 1 ? grant_q[1] : 99, 3);

    // Fairness: all four requesters streaming, expect strict rotation from 0.
    grant_q.delete();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) begin
        x = k * 7 + i + 1;
        y = i + 2;
        v = '{i, int2fp(x), int2fp(y), k[0], (k[0] ? int2fp(x - y) : int2fp(x + y))};
        push(v);
      end
    end
    wait_idle("fair_idle", 100);
    chk("fair_grant_count", grant_q.size(), 12);
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("fair_grant[%0d]", k), grant_q.size() > k ? grant_q[k] : 99, k % N);
    end

    // Three more ops bring the post-reset total to 17; a 4-bit counter reads 1.
    for (int i = 1; i < N; i++) push('{i, int2fp(i), int2fp(i), 1'b0, int2fp(2 * i)});
    wait_idle("wrap_idle", 50);
    chk("op_count_wrap_17", op_count, CW'(tot_ops % 16));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
